mind_run_sequencer: RTL and testbench

- Controller that sequences the tinymind counting engine through a requested number of back-to-back passes.
- Per pass: holds the engine in reset for a fixed window, releases it, then waits for done_r to rise.
- Accepts run commands over a valid/ready handshake and reports per-pass progress, completion, abort and timeout.
- Sits between a host/control FSM and one tinymind instance; it owns that instance's reset.

---
 rtl/mind_run_sequencer.sv | 141 ++++++++++++++
 tb/tb_mind_run_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mind_run_sequencer.sv
// Sequences one tinymind engine through N back-to-back passes: reset window, release,
// wait for done_r to rise; reports progress, completion, abort and watchdog timeout.
//   state | meaning
//   IDLE  | engine held in reset, ready for a run request
//   ERST  | engine held in reset for RST_CYCLES before a pass
//   RUN   | engine released, waiting for done_r rise under watchdog
//   FIN   | one-cycle completion, done_pulse high
module mind_run_sequencer #(
  parameter int PASS_W     = 4,
  parameter int RST_CYCLES = 5,
  parameter int TIMEOUT    = 64,
  parameter int TO_W       = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [PASS_W-1:0] start_passes,
  input  logic              abort,
  output logic              eng_rst_n,
  input  logic              eng_done_r,
  output logic              busy,
  output logic [PASS_W-1:0] pass_idx,
  output logic              done_pulse,
  output logic              err_timeout,
  output logic              err_abort
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ERST, RUN, FIN} state_t;

  state_t            state_q, state_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic [PASS_W-1:0] pass_idx_q, pass_idx_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic              err_to_q, err_to_d;
  logic              err_ab_q, err_ab_d;
  logic              done_prev_q;
  logic              start_ready_q, busy_q, eng_rst_n_q, done_pulse_q;
  logic              accept, rise;
  logic [PASS_W-1:0] pass_inc;

  // start_ready_q is high exactly when the FSM sits in IDLE
  assign accept   = start_valid && start_ready_q;
  assign rise     = (state_q == RUN) && eng_done_r && !done_prev_q;
  assign pass_inc = pass_idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    passes_d   = passes_q;
    pass_idx_d = pass_idx_q;
    rst_cnt_d  = rst_cnt_q;
    wd_d       = wd_q;
    err_to_d   = err_to_q;
    err_ab_d   = err_ab_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          passes_d   = start_passes;
          pass_idx_d = '0;
          err_to_d   = 1'b0;
          err_ab_d   = 1'b0;
          rst_cnt_d  = '0;
          state_d    = (start_passes == '0) ? FIN : ERST;
        end
      end
      ERST: begin
        if (abort) begin
          err_ab_d = 1'b1;
          state_d  = FIN;
        end else if (rst_cnt_q == RC_LAST) begin
          wd_d    = '0;
          state_d = RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      RUN: begin
        // abort beats a same-cycle rise; a rise beats a same-cycle timeout
        if (abort) begin
          err_ab_d = 1'b1;
          state_d  = FIN;
        end else if (rise) begin
          pass_idx_d = pass_inc;
          rst_cnt_d  = '0;
          state_d    = (pass_inc == passes_q) ? FIN : ERST;
        end else if (wd_q == TO_LAST) begin
          err_to_d = 1'b1;
          state_d  = FIN;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      passes_q      <= '0;
      pass_idx_q    <= '0;
      rst_cnt_q     <= '0;
      wd_q          <= '0;
      err_to_q      <= 1'b0;
      err_ab_q      <= 1'b0;
      done_prev_q   <= 1'b0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      eng_rst_n_q   <= 1'b0;
      done_pulse_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      passes_q      <= passes_d;
      pass_idx_q    <= pass_idx_d;
      rst_cnt_q     <= rst_cnt_d;
      wd_q          <= wd_d;
      err_to_q      <= err_to_d;
      err_ab_q      <= err_ab_d;
      done_prev_q   <= (state_q == RUN) ? eng_done_r : 1'b0;
      start_ready_q <= (state_d == IDLE);
      busy_q        <= (state_d != IDLE);
      eng_rst_n_q   <= (state_d == RUN);
      done_pulse_q  <= (state_d == FIN);
    end
  end

  assign start_ready = start_ready_q;
  assign busy        = busy_q;
  assign eng_rst_n   = eng_rst_n_q;
  assign pass_idx    = pass_idx_q;
  assign done_pulse  = done_pulse_q;
  assign err_timeout = err_to_q;
  assign err_abort   = err_ab_q;

endmodule

// File: tb/tb_mind_run_sequencer.sv
// Bench for mind_run_sequencer with a behavioural counting engine; per-run results
// are queued at request time and compared when done_pulse appears.
module tb_mind_run_sequencer;
  localparam int PASS_W = 4;
  localparam int RST_CYCLES = 5;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_valid = 1'b0;
  logic              start_ready;
  logic [PASS_W-1:0] start_passes = '0;
  logic              abort = 1'b0;
  logic              eng_rst_n;
  logic              busy;
  logic [PASS_W-1:0] pass_idx;
  logic              done_pulse;
  logic              err_timeout;
  logic              err_abort;

  int   eng_max = 14;
  int   eng_cnt = 0;
  logic eng_done = 1'b0;

  always #5 clk = ~clk;

  mind_run_sequencer #(.PASS_W(PASS_W), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .start_passes(start_passes), .abort(abort), .eng_rst_n(eng_rst_n), .eng_done_r(eng_done),
    .busy(busy), .pass_idx(pass_idx), .done_pulse(done_pulse), .err_timeout(err_timeout),
    .err_abort(err_abort));

  // engine: counts up from 0 after release, done_r goes high once the count hits eng_max
  always @(posedge clk) begin
    if (eng_rst_n !== 1'b1) begin
      eng_cnt  <= 0;
      eng_done <= 1'b0;
    end else if (eng_cnt == eng_max) begin
      eng_done <= 1'b1;
    end else begin
      eng_cnt <= eng_cnt + 1;
    end
  end

  typedef struct {
    logic [PASS_W-1:0] pidx;
    logic              to;
    logic              ab;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  int w_erst, w_windows, w_zero, w_run, w_pchg;
  bit w_pmono, w_done;

  task automatic do_start(input logic [PASS_W-1:0] n, output bit ok);
    start_passes = n;
    start_valid  = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (start_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    start_valid = 1'b0;
  endtask

  // observes from the current negedge until done_pulse is seen (returns on that sample)
  task automatic watch_run(input int budget);
    logic              prev_rst = eng_rst_n;
    logic [PASS_W-1:0] prev_p = pass_idx;
    bit                zero_seen = 1'b0;
    w_erst = 0; w_windows = 0; w_zero = 0; w_run = 0; w_pchg = 0;
    w_pmono = 1'b1; w_done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (pass_idx != prev_p) begin
        w_pchg++;
        if (int'(pass_idx) != int'(prev_p) + 1) w_pmono = 1'b0;
      end
      prev_p = pass_idx;
      if (done_pulse) begin
        w_done = 1'b1;
        break;
      end
      if (eng_rst_n && !prev_rst) begin
        w_windows++;
        if (zero_seen) w_zero++;
        zero_seen = 1'b0;
      end
      if (!eng_rst_n) begin
        w_erst++;
        if (eng_cnt == 0) zero_seen = 1'b1;
      end else begin
        w_run++;
      end
      prev_rst = eng_rst_n;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({eng_rst_n, start_ready, busy, pass_idx, done_pulse, err_timeout, err_abort} !==
        {1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0})
      begin errors++; $display("FAIL reset_values got %b", {eng_rst_n, start_ready, busy, pass_idx, done_pulse, err_timeout, err_abort}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({eng_rst_n, start_ready, busy, done_pulse} !== 4'b0100)
      begin errors++; $display("FAIL idle_after_reset got %b want 0100", {eng_rst_n, start_ready, busy, done_pulse}); end
  endtask

  task automatic test_single();
    bit ok;
    exp_t e;
    eng_max = 14;
    sb.push_back('{4'd1, 1'b0, 1'b0});
    do_start(4'd1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_accept got timeout"); end
    watch_run(300);
    checks++; if (!w_done) begin errors++; $display("FAIL single_done got none within budget"); end
    checks++; if (w_erst != RST_CYCLES) begin errors++; $display("FAIL single_erst got %0d want %0d", w_erst, RST_CYCLES); end
    checks++; if (w_run != eng_max + 2) begin errors++; $display("FAIL single_run_len got %0d want %0d", w_run, eng_max + 2); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_at_done got %b want 1", busy); end
    e = sb.pop_front();
    checks++;
    if ({pass_idx, err_timeout, err_abort} !== {e.pidx, e.to, e.ab})
      begin errors++; $display("FAIL single_result got %h/%b/%b want %h/%b/%b", pass_idx, err_timeout, err_abort, e.pidx, e.to, e.ab); end
    @(negedge clk);
    checks++;
    if ({busy, done_pulse, start_ready} !== 3'b001)
      begin errors++; $display("FAIL single_after_fin got %b want 001", {busy, done_pulse, start_ready}); end
  endtask

  task automatic test_multi();
    bit ok;
    exp_t e;
    eng_max = 14;
    sb.push_back('{4'd3, 1'b0, 1'b0});
    do_start(4'd3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL multi_accept got timeout"); end
    watch_run(500);
    checks++; if (!w_done) begin errors++; $display("FAIL multi_done got none within budget"); end
    checks++; if (w_erst != 3 * RST_CYCLES) begin errors++; $display("FAIL multi_erst got %0d want %0d", w_erst, 3 * RST_CYCLES); end
    checks++; if (w_windows != 3) begin errors++; $display("FAIL multi_windows got %0d want 3", w_windows); end
    checks++; if (w_zero != 3) begin errors++; $display("FAIL multi_engine_zero got %0d want 3", w_zero); end
    checks++; if (w_pchg != 3 || !w_pmono) begin errors++; $display("FAIL multi_pass_steps got %0d mono %0d want 3 mono 1", w_pchg, w_pmono); end
    e = sb.pop_front();
    checks++;
    if ({pass_idx, err_timeout, err_abort} !== {e.pidx, e.to, e.ab})
      begin errors++; $display("FAIL multi_result got %h/%b/%b want %h/%b/%b", pass_idx, err_timeout, err_abort, e.pidx, e.to, e.ab); end
    @(negedge clk);
  endtask

  task automatic test_zero();
    bit ok;
    exp_t e;
    sb.push_back('{4'd0, 1'b0, 1'b0});
    do_start(4'd0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_accept got timeout"); end
    watch_run(10);
    checks++; if (!w_done || w_windows != 0 || w_erst != 0) begin errors++; $display("FAIL zero_fin got done %0d windows %0d erst %0d want 1 0 0", w_done, w_windows, w_erst); end
    checks++; if ({busy, eng_rst_n} !== 2'b10) begin errors++; $display("FAIL zero_busy got %b want 10", {busy, eng_rst_n}); end
    e = sb.pop_front();
    checks++;
    if ({pass_idx, err_timeout, err_abort} !== {e.pidx, e.to, e.ab})
      begin errors++; $display("FAIL zero_result got %h/%b/%b want %h/%b/%b", pass_idx, err_timeout, err_abort, e.pidx, e.to, e.ab); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_len got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    bit ok;
    exp_t e;
    eng_max = 200;
    sb.push_back('{4'd0, 1'b1, 1'b0});
    do_start(4'd2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL timeout_accept got timeout"); end
    watch_run(400);
    checks++; if (!w_done) begin errors++; $display("FAIL timeout_done got none within budget"); end
    checks++; if (w_run != TIMEOUT) begin errors++; $display("FAIL timeout_run_len got %0d want %0d", w_run, TIMEOUT); end
    checks++; if (eng_rst_n !== 1'b0) begin errors++; $display("FAIL timeout_eng_rst got %b want 0", eng_rst_n); end
    e = sb.pop_front();
    checks++;
    if ({pass_idx, err_timeout, err_abort} !== {e.pidx, e.to, e.ab})
      begin errors++; $display("FAIL timeout_result got %h/%b/%b want %h/%b/%b", pass_idx, err_timeout, err_abort, e.pidx, e.to, e.ab); end
    repeat (2) @(negedge clk);
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", err_timeout); end
    eng_max = 14;
  endtask

  task automatic test_abort();
    bit ok, found;
    exp_t e;
    eng_max = 14;
    sb.push_back('{4'd1, 1'b0, 1'b1});
    do_start(4'd3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_accept got timeout"); end
    found = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (pass_idx == 4'd1 && eng_rst_n) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL abort_second_pass got none within budget"); end
    repeat (3) @(negedge clk);
    abort = 1'b1;
    watch_run(10);
    abort = 1'b0;
    checks++; if (!w_done) begin errors++; $display("FAIL abort_done got none within budget"); end
    e = sb.pop_front();
    checks++;
    if ({pass_idx, err_timeout, err_abort} !== {e.pidx, e.to, e.ab})
      begin errors++; $display("FAIL abort_result got %h/%b/%b want %h/%b/%b", pass_idx, err_timeout, err_abort, e.pidx, e.to, e.ab); end
    @(negedge clk);
  endtask

  task automatic test_collision();
    bit ok, found;
    exp_t e;
    eng_max = 14;
    sb.push_back('{4'd0, 1'b0, 1'b1});
    do_start(4'd2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL collide_accept got timeout"); end
    found = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (eng_done) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL collide_rise got none within budget"); end
    abort = 1'b1;
    watch_run(10);
    abort = 1'b0;
    checks++; if (!w_done) begin errors++; $display("FAIL collide_done got none within budget"); end
    e = sb.pop_front();
    checks++;
    if ({pass_idx, err_timeout, err_abort} !== {e.pidx, e.to, e.ab})
      begin errors++; $display("FAIL collide_result got %h/%b/%b want %h/%b/%b", pass_idx, err_timeout, err_abort, e.pidx, e.to, e.ab); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad_ready;
    exp_t e;
    eng_max = 14;
    sb.push_back('{4'd1, 1'b0, 1'b0});
    sb.push_back('{4'd2, 1'b0, 1'b0});
    do_start(4'd1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_accept got timeout"); end
    start_passes = 4'd2;
    start_valid  = 1'b1;
    bad_ready = 0;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (done_pulse) begin ok = 1'b1; break; end
      if (start_ready) bad_ready++;
      @(negedge clk);
    end
    checks++; if (!ok || bad_ready != 0) begin errors++; $display("FAIL b2b_hold got done %0d ready_while_busy %0d want 1 0", ok, bad_ready); end
    e = sb.pop_front();
    checks++;
    if ({pass_idx, err_timeout, err_abort} !== {e.pidx, e.to, e.ab})
      begin errors++; $display("FAIL b2b_first_result got %h/%b/%b want %h/%b/%b", pass_idx, err_timeout, err_abort, e.pidx, e.to, e.ab); end
    @(negedge clk);
    checks++; if ({busy, start_ready} !== 2'b01) begin errors++; $display("FAIL b2b_idle_gap got %b want 01", {busy, start_ready}); end
    @(negedge clk);
    start_valid = 1'b0;
    checks++; if ({busy, start_ready, pass_idx} !== {1'b1, 1'b0, 4'd0}) begin errors++; $display("FAIL b2b_second_accept got %b want 100000", {busy, start_ready, pass_idx}); end
    watch_run(500);
    checks++; if (!w_done) begin errors++; $display("FAIL b2b_second_done got none within budget"); end
    e = sb.pop_front();
    checks++;
    if ({pass_idx, err_timeout, err_abort} !== {e.pidx, e.to, e.ab})
      begin errors++; $display("FAIL b2b_second_result got %h/%b/%b want %h/%b/%b", pass_idx, err_timeout, err_abort, e.pidx, e.to, e.ab); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok, found;
    int pulses;
    sb.push_back('{4'd2, 1'b0, 1'b0});
    do_start(4'd2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_accept got timeout"); end
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (eng_rst_n) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_run got none within budget"); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({eng_rst_n, start_ready, busy, pass_idx, done_pulse, err_timeout, err_abort} !==
        {1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0})
      begin errors++; $display("FAIL rstmid_values got %b", {eng_rst_n, start_ready, busy, pass_idx, done_pulse, err_timeout, err_abort}); end
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_pulse) pulses++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done_pulse || busy) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rstmid_no_pulse got %0d want 0", pulses); end
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_multi();
    test_zero();
    test_timeout();
    test_abort();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
